// File: rtl/wb_unit.sv
// Registered MEM/WB write-back stage: captures one instruction, waits for load data,
// formats loads and drives the register-file write port plus hazard-visible pending state.
module wb_unit #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_alu_result,
  input  logic [XLEN-1:0]   in_pc_plus4,
  input  logic [REG_AW-1:0] in_rd,
  input  logic              in_reg_write,
  input  logic [1:0]        in_wb_sel,
  input  logic [1:0]        in_load_size,
  input  logic              in_load_unsigned,
  input  logic              mem_rsp_valid,
  input  logic [XLEN-1:0]   mem_rsp_data,
  input  logic              flush,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [XLEN-1:0]   rf_wdata,
  output logic              pend_valid,
  output logic [REG_AW-1:0] pend_rd
);

  localparam int unsigned OffW = (XLEN == 64) ? 3 : 2;

  typedef enum logic [1:0] {StIdle, StWaitMem, StWrite} state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   alu_q, pc_q, load_q;
  logic [REG_AW-1:0] rd_q;
  logic              reg_write_q, unsigned_q;
  logic [1:0]        wb_sel_q, size_q;
  logic              accept;

  logic [OffW-1:0]   lane_mask, byte_off;
  logic [XLEN-1:0]   shifted, load_fmt;

  assign in_ready = !flush && (state_q == StIdle || state_q == StWrite);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StWrite: begin
        if (accept) state_d = (in_wb_sel == 2'b01) ? StWaitMem : StWrite;
        else        state_d = StIdle;
      end
      StWaitMem: begin
        if (flush)              state_d = StIdle;
        else if (mem_rsp_valid) state_d = StWrite;
      end
      default: state_d = StIdle;
    endcase
  end

  // Masking the low address bits by access size picks the naturally aligned lane.
  always_comb begin
    lane_mask = {OffW{1'b1}} << size_q;
    byte_off  = alu_q[OffW-1:0] & lane_mask;
    shifted   = mem_rsp_data >> {byte_off, 3'b000};
    load_fmt  = shifted;
    unique case (size_q)
      2'b00: begin
        if (unsigned_q) load_fmt = XLEN'(shifted[7:0]);
        else            load_fmt = XLEN'($signed(shifted[7:0]));
      end
      2'b01: begin
        if (unsigned_q) load_fmt = XLEN'(shifted[15:0]);
        else            load_fmt = XLEN'($signed(shifted[15:0]));
      end
      2'b10: begin
        if (unsigned_q) load_fmt = XLEN'(shifted[31:0]);
        else            load_fmt = XLEN'($signed(shifted[31:0]));
      end
      default: load_fmt = shifted;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      alu_q       <= '0;
      pc_q        <= '0;
      load_q      <= '0;
      rd_q        <= '0;
      reg_write_q <= 1'b0;
      unsigned_q  <= 1'b0;
      wb_sel_q    <= 2'b00;
      size_q      <= 2'b00;
    end else begin
      state_q <= state_d;
      if (accept) begin
        alu_q       <= in_alu_result;
        pc_q        <= in_pc_plus4;
        rd_q        <= in_rd;
        reg_write_q <= in_reg_write;
        unsigned_q  <= in_load_unsigned;
        wb_sel_q    <= in_wb_sel;
        size_q      <= in_load_size;
      end
      if (state_q == StWaitMem && mem_rsp_valid && !flush) load_q <= load_fmt;
    end
  end

  assign rf_we      = (state_q == StWrite) && reg_write_q && (rd_q != '0);
  assign pend_valid = (state_q == StWaitMem) && reg_write_q && (rd_q != '0);
  assign pend_rd    = pend_valid ? rd_q : '0;

  always_comb begin
    rf_waddr = '0;
    rf_wdata = '0;
    if (rf_we) begin
      rf_waddr = rd_q;
      unique case (wb_sel_q)
        2'b01:   rf_wdata = load_q;
        2'b10:   rf_wdata = pc_q;
        default: rf_wdata = alu_q;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_unit.sv
// Drives XLEN=32 and XLEN=64 instances with shared stimulus and checks them against a
// transaction-level model of the held instruction.
module tb_wb_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_reg_write, in_load_unsigned, mem_rsp_valid, flush;
  logic [63:0] in_alu_result, in_pc_plus4, mem_rsp_data;
  logic [4:0]  in_rd;
  logic [1:0]  in_wb_sel, in_load_size;

  logic        in_ready32, rf_we32, pend_valid32;
  logic [4:0]  rf_waddr32, pend_rd32;
  logic [31:0] rf_wdata32;
  logic        in_ready64, rf_we64, pend_valid64;
  logic [4:0]  rf_waddr64, pend_rd64;
  logic [63:0] rf_wdata64;

  int checks = 0;
  int errors = 0;

  // Model: the instruction held by the unit, whether its load data has arrived.
  logic        m_has, m_got, m_rw, m_uns;
  logic [4:0]  m_rd;
  logic [1:0]  m_sel, m_size;
  logic [63:0] m_alu, m_pc, m_data;

  wb_unit #(.XLEN(32), .REG_AW(5)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready32),
    .in_alu_result(in_alu_result[31:0]), .in_pc_plus4(in_pc_plus4[31:0]), .in_rd(in_rd),
    .in_reg_write(in_reg_write), .in_wb_sel(in_wb_sel), .in_load_size(in_load_size),
    .in_load_unsigned(in_load_unsigned), .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_data(mem_rsp_data[31:0]), .flush(flush), .rf_we(rf_we32), .rf_waddr(rf_waddr32),
    .rf_wdata(rf_wdata32), .pend_valid(pend_valid32), .pend_rd(pend_rd32)
  );

  wb_unit #(.XLEN(64), .REG_AW(5)) dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready64),
    .in_alu_result(in_alu_result), .in_pc_plus4(in_pc_plus4), .in_rd(in_rd),
    .in_reg_write(in_reg_write), .in_wb_sel(in_wb_sel), .in_load_size(in_load_size),
    .in_load_unsigned(in_load_unsigned), .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_data(mem_rsp_data), .flush(flush), .rf_we(rf_we64), .rf_waddr(rf_waddr64),
    .rf_wdata(rf_wdata64), .pend_valid(pend_valid64), .pend_rd(pend_rd64)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Load result from first principles: pick the aligned lane, then extend.
  function automatic logic [63:0] fmt_ref(input logic [63:0] data, input logic [63:0] addr,
                                          input logic [1:0] size, input logic uns,
                                          input int xlen);
    int nbytes, wbytes, off;
    logic [127:0] v, m;
    wbytes = xlen / 8;
    nbytes = 1 << size;
    if (nbytes > wbytes) nbytes = wbytes;
    off = ((int'(addr[2:0]) % wbytes) / nbytes) * nbytes;
    m = (128'd1 << (8 * nbytes)) - 128'd1;
    v = ({64'd0, data} >> (8 * off)) & m;
    if (!uns && v[8 * nbytes - 1]) v = v | ~m;
    if (xlen == 32) return {32'd0, v[31:0]};
    return v[63:0];
  endfunction

  task automatic check_outputs();
    logic wr, we, pv;
    logic [63:0] r64, r32;
    wr = m_has && (m_sel != 2'b01 || m_got);
    we = wr && m_rw && (m_rd != 5'd0);
    pv = m_has && (m_sel == 2'b01) && !m_got && m_rw && (m_rd != 5'd0);
    case (m_sel)
      2'b01: begin
        r64 = fmt_ref(m_data, m_alu, m_size, m_uns, 64);
        r32 = fmt_ref({32'd0, m_data[31:0]}, m_alu, m_size, m_uns, 32);
      end
      2'b10:   begin r64 = m_pc;  r32 = {32'd0, m_pc[31:0]};  end
      default: begin r64 = m_alu; r32 = {32'd0, m_alu[31:0]}; end
    endcase
    chk("rf_we32", rf_we32, we);
    chk("rf_we64", rf_we64, we);
    chk("rf_waddr32", rf_waddr32, we ? m_rd : 5'd0);
    chk("rf_waddr64", rf_waddr64, we ? m_rd : 5'd0);
    if (!(m_sel == 2'b01 && m_size == 2'b11)) chk("rf_wdata32", rf_wdata32, we ? r32 : 64'd0);
    chk("rf_wdata64", rf_wdata64, we ? r64 : 64'd0);
    chk("pend_valid32", pend_valid32, pv);
    chk("pend_valid64", pend_valid64, pv);
    chk("pend_rd32", pend_rd32, pv ? m_rd : 5'd0);
    chk("pend_rd64", pend_rd64, pv ? m_rd : 5'd0);
  endtask

  // Called at posedge+1 with inputs set; returns at the next posedge+1.
  task automatic step();
    logic waiting, ready;
    #1;
    waiting = m_has && (m_sel == 2'b01) && !m_got;
    ready   = !flush && !waiting;
    chk("in_ready32", in_ready32, ready);
    chk("in_ready64", in_ready64, ready);
    if (waiting) begin
      if (flush) m_has = 1'b0;
      else if (mem_rsp_valid) begin
        m_got  = 1'b1;
        m_data = mem_rsp_data;
      end
    end else if (in_valid && ready) begin
      m_has = 1'b1; m_got = 1'b0;
      m_rw = in_reg_write; m_uns = in_load_unsigned; m_rd = in_rd;
      m_sel = in_wb_sel; m_size = in_load_size; m_alu = in_alu_result; m_pc = in_pc_plus4;
    end else begin
      m_has = 1'b0;
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic set_in(input logic v, input logic [1:0] sel, input logic [4:0] r,
                        input logic w, input logic [63:0] a, input logic [63:0] pc,
                        input logic [1:0] sz, input logic u);
    in_valid = v; in_wb_sel = sel; in_rd = r; in_reg_write = w;
    in_alu_result = a; in_pc_plus4 = pc; in_load_size = sz; in_load_unsigned = u;
    mem_rsp_valid = 1'b0; flush = 1'b0;
  endtask

  task automatic idle(input logic rv, input logic [63:0] rd_data, input logic fl);
    in_valid = 1'b0; mem_rsp_valid = rv; mem_rsp_data = rd_data; flush = fl;
  endtask

  // Accept a load, wait `gap` cycles, then deliver data.
  task automatic load_op(input logic [63:0] addr, input logic [1:0] sz, input logic u,
                         input logic [4:0] r, input int gap, input logic [63:0] data);
    set_in(1'b1, 2'b01, r, 1'b1, addr, 64'h0, sz, u);
    step();
    for (int i = 0; i < gap; i++) begin
      idle(1'b0, 64'h0, 1'b0);
      step();
    end
    idle(1'b1, data, 1'b0);
    step();
  endtask

  initial begin
    m_has = 1'b0; m_got = 1'b0; m_rw = 1'b0; m_uns = 1'b0; m_rd = '0;
    m_sel = '0; m_size = '0; m_alu = '0; m_pc = '0; m_data = '0;
    rst_n = 1'b0;
    set_in(1'b1, 2'b00, 5'd3, 1'b1, 64'h99, 64'h0, 2'b00, 1'b0);
    mem_rsp_data = 64'h0;
    #23;
    chk("rst_in_ready32", in_ready32, 1'b1);
    chk("rst_in_ready64", in_ready64, 1'b1);
    check_outputs();
    in_valid = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // First accept after reset.
    set_in(1'b1, 2'b00, 5'd7, 1'b1, 64'h55, 64'h0, 2'b00, 1'b0);
    step();
    chk("first_write", rf_wdata32, 64'h55);

    // Back-to-back ALU ops.
    set_in(1'b1, 2'b00, 5'd1, 1'b1, 64'h11, 64'h0, 2'b00, 1'b0); step();
    chk("b2b_1", rf_wdata32, 64'h11);
    set_in(1'b1, 2'b00, 5'd2, 1'b1, 64'h22, 64'h0, 2'b00, 1'b0); step();
    chk("b2b_2", rf_wdata32, 64'h22);
    set_in(1'b1, 2'b00, 5'd3, 1'b1, 64'h33, 64'h0, 2'b00, 1'b0); step();
    chk("b2b_3", rf_wdata32, 64'h33);
    idle(1'b0, 64'h0, 1'b0); step();

    // Loads with a 3-cycle response delay.
    load_op(64'h1002, 2'b00, 1'b0, 5'd5, 2, 64'h80FF7F00);
    chk("lb", rf_wdata32, 64'hFFFFFFFF);
    idle(1'b0, 64'h0, 1'b0); step();
    load_op(64'h1002, 2'b00, 1'b1, 5'd5, 2, 64'h80FF7F00);
    chk("lbu", rf_wdata32, 64'h000000FF);
    idle(1'b0, 64'h0, 1'b0); step();
    load_op(64'h1002, 2'b01, 1'b0, 5'd5, 2, 64'h80FF7F00);
    chk("lh", rf_wdata32, 64'hFFFF80FF);
    idle(1'b0, 64'h0, 1'b0); step();

    // jal, then the same to x0.
    set_in(1'b1, 2'b10, 5'd1, 1'b1, 64'h0, 64'h104, 2'b00, 1'b0); step();
    chk("jal", rf_wdata32, 64'h104);
    set_in(1'b1, 2'b10, 5'd0, 1'b1, 64'h0, 64'h104, 2'b00, 1'b0); step();
    chk("jal_x0", rf_we32, 1'b0);
    idle(1'b0, 64'h0, 1'b0); step();

    // Flush while waiting, stray response later.
    set_in(1'b1, 2'b01, 5'd6, 1'b1, 64'h0, 64'h0, 2'b10, 1'b0); step();
    idle(1'b0, 64'h0, 1'b1); step();
    idle(1'b0, 64'h0, 1'b0); step();
    idle(1'b1, 64'hDEAD, 1'b0); step();
    chk("flush_wait_no_we", rf_we32, 1'b0);

    // Flush coinciding with a write.
    set_in(1'b1, 2'b00, 5'd9, 1'b1, 64'h77, 64'h0, 2'b00, 1'b0); step();
    in_valid = 1'b1; flush = 1'b1;
    #1 chk("flush_write_ready", in_ready32, 1'b0);
    chk("flush_write_we", rf_we32, 1'b1);
    step();
    idle(1'b0, 64'h0, 1'b0); step();

    // Doubleword-datapath word/double loads.
    load_op(64'h0, 2'b10, 1'b0, 5'd4, 0, 64'h00000000_80000000);
    chk("lw64", rf_wdata64, 64'hFFFFFFFF_80000000);
    load_op(64'h0, 2'b10, 1'b1, 5'd4, 0, 64'h00000000_80000000);
    chk("lwu64", rf_wdata64, 64'h00000000_80000000);
    load_op(64'h0, 2'b11, 1'b0, 5'd4, 1, 64'h8123_4567_89AB_CDEF);
    chk("ld64", rf_wdata64, 64'h8123_4567_89AB_CDEF);
    idle(1'b0, 64'h0, 1'b0); step();

    // Reset while a load is pending.
    set_in(1'b1, 2'b01, 5'd8, 1'b1, 64'h0, 64'h0, 2'b10, 1'b0); step();
    idle(1'b0, 64'h0, 1'b0);
    rst_n = 1'b0;
    m_has = 1'b0;
    #2;
    chk("rst_mid_pend", pend_valid32, 1'b0);
    chk("rst_mid_ready", in_ready64, 1'b1);
    check_outputs();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      set_in($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             $urandom_range(0, 7) != 0, {$urandom(), $urandom()}, {$urandom(), $urandom()},
             2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      mem_rsp_valid = ($urandom_range(0, 2) == 0);
      mem_rsp_data  = {$urandom(), $urandom()};
      flush         = ($urandom_range(0, 9) == 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
